// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with a runtime baud divisor and a
// small show-ahead receive FIFO.
// Build option: define UART_RX_PARITY_EN to enable the optional parity bit.
// Without it, parity_en and parity_odd are ignored and parity_err stays 0.
module uart_rx_ext #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic [DIV_W-1:0]  div,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
    } state_t;
`endif

    // ---------------- synchroniser ----------------
    logic rx_meta_reg;
    logic rxs_reg;
    logic rxs_prev_reg;

    // Two-flop synchroniser plus one history flop for falling-edge detection;
    // preset high so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rxs_reg      <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg  <= rx;
            rxs_reg      <= rx_meta_reg;
            rxs_prev_reg <= rxs_reg;
        end
    end

    // ---------------- receive FSM ----------------
    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   cnt_reg, cnt_next;
    logic [DIV_W-1:0]   div_q_reg, div_q_next;
    logic [3:0]         bit_idx_reg, bit_idx_next;
    logic [DATA_W-1:0]  shift_reg, shift_next;
    logic               push_reg, push_next;
    logic               frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic               par_en_reg, par_en_next;
    logic               par_odd_reg, par_odd_next;
    logic               par_flag_reg, par_flag_next;
    logic               parity_err_reg, parity_err_next;
`else
    logic               unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    logic bit_sample;
    logic half_sample;
    assign bit_sample  = (cnt_reg == div_q_reg - DIV_W'(1));
    assign half_sample = (cnt_reg == (div_q_reg >> 1));

    // FSM state and frame datapath registers; frame settings are captured
    // at start detection so later input changes do not disturb the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            div_q_reg      <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            push_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_reg     <= 1'b0;
            par_odd_reg    <= 1'b0;
            par_flag_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            div_q_reg      <= div_q_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            push_reg       <= push_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            par_en_reg     <= par_en_next;
            par_odd_reg    <= par_odd_next;
            par_flag_reg   <= par_flag_next;
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    // Next-state logic: bit timing, data shifting and end-of-frame verdict.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        div_q_next      = div_q_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        push_next       = 1'b0;
        frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_next     = par_en_reg;
        par_odd_next    = par_odd_reg;
        par_flag_next   = par_flag_reg;
        parity_err_next = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (rxs_prev_reg && !rxs_reg) begin
                    div_q_next    = div;
                    cnt_next      = '0;
                    state_next    = S_START;
`ifdef UART_RX_PARITY_EN
                    par_en_next   = parity_en;
                    par_odd_next  = parity_odd;
                    par_flag_next = 1'b0;
`endif
                end
            end
            S_START: begin
                if (half_sample) begin
                    cnt_next = '0;
                    if (!rxs_reg) begin
                        bit_idx_next = '0;
                        state_next   = S_DATA;
                    end else begin
                        state_next   = S_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_sample) begin
                    cnt_next     = '0;
                    shift_next   = {rxs_reg, shift_reg[DATA_W-1:1]};
                    bit_idx_next = bit_idx_reg + 4'd1;
                    if (bit_idx_reg == 4'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = par_en_reg ? S_PARITY : S_STOP;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_sample) begin
                    cnt_next      = '0;
                    par_flag_next = ((^shift_reg) ^ rxs_reg) != par_odd_reg;
                    state_next    = S_STOP;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_sample) begin
                    cnt_next = '0;
                    if (rxs_reg) begin
`ifdef UART_RX_PARITY_EN
                        if (par_flag_reg) parity_err_next = 1'b1;
                        else              push_next       = 1'b1;
`else
                        push_next = 1'b1;
`endif
                        state_next = S_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_WAIT_HI;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            S_WAIT_HI: begin
                if (rxs_reg) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign frame_err = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    // ---------------- receive FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign do_pop  = rd_en && (count_reg != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // still succeeds when the reader is draining.
    assign do_push = push_reg && (!full || do_pop);
    assign overrun = push_reg && full && !do_pop;

    // Pointer/count update and next head word; the head is re-read every
    // cycle from the post-update read pointer, bypassing a same-cycle write.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        rd_data_next = rd_data_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
        if (count_next != '0) begin
            if (do_push && (wr_ptr_reg == rd_ptr_next)) rd_data_next = shift_reg;
            else                                        rd_data_next = mem[rd_ptr_next];
        end
    end

    // Storage array, written only; no reset so it maps onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= shift_reg;
    end

    // FIFO control registers and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            rd_data_reg <= rd_data_next;
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = (count_reg != '0);

endmodule
